// File: rtl/rx_serial.sv
// rx_serial: serial-to-parallel receiver for the tx_serial link.
// Captures one bit per clock while ena_i is high, MSB first, and presents
// each completed Width-bit word on data_o with a one-cycle valid_o strobe.
//
// Optional feature macro: RX_SERIAL_ERR_EN
//   defined   : ena_i low in the middle of a word is a framing error; the
//               partial word is dropped and err_o pulses for one cycle.
//   undefined : ena_i low in the middle of a word pauses reception; err_o
//               is tied low.
module rx_serial #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_i,
    input  logic             ena_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int CW = $clog2(Width + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(Width - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [Width-1:0] sr_r;
    logic [Width-1:0] sr_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic [Width-1:0] data_r;
    logic [Width-1:0] data_s;
    logic             valid_r;
    logic             valid_s;
    logic             err_r;
    logic             err_s;
    logic [Width-1:0] shifted_s;

    // Shift register contents with the current serial bit appended (MSB first).
    always_comb begin
        shifted_s = {sr_r[Width-2:0], data_i};
    end

    // Next-state and next-output logic for the word assembly FSM.
    always_comb begin
        state_s = state_r;
        sr_s    = sr_r;
        cnt_s   = cnt_r;
        data_s  = data_r;
        valid_s = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ena_i) begin
                    sr_s    = shifted_s;
                    cnt_s   = CNT_ONE;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (ena_i) begin
                    sr_s = shifted_s;
                    if (cnt_r == CNT_LAST) begin
                        // Last bit of the word: publish it and free the FSM so
                        // a following bit on the next edge starts a new word.
                        data_s  = shifted_s;
                        valid_s = 1'b1;
                        cnt_s   = CNT_ZERO;
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
`ifdef RX_SERIAL_ERR_EN
                    // Framing error: drop the partial word, keep data_o.
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                    err_s   = 1'b1;
`else
                    // Pause: everything holds until ena_i returns.
                    state_s = SHIFT;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers; reset discards any partial word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            sr_r    <= '0;
            cnt_r   <= CNT_ZERO;
            data_r  <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            err_r   <= err_s;
        end
    end

    // Output mapping; busy is decoded directly from the state register.
    always_comb begin
        data_o  = data_r;
        valid_o = valid_r;
        busy_o  = (state_r == SHIFT);
`ifdef RX_SERIAL_ERR_EN
        err_o   = err_r;
`else
        err_o   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rx_serial.sv
// tb_rx_serial: randomized/directed stimulus with a queue-based reference
// model; a negedge monitor pops expected words/errors and compares.
module tb_rx_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         din;
    logic         ena;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         busy_o;
    logic         err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit           partial[$];
    logic [W-1:0] exp_words[$];
    int           exp_errs;
    logic [W-1:0] last_word;

    rx_serial #(.Width(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (din),
        .ena_i  (ena),
        .data_o (data_o),
        .valid_o(valid_o),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic model_clear();
        partial.delete();
        exp_words.delete();
        exp_errs  = 0;
        last_word = '0;
    endtask

    // Apply one bit slot: inputs are held across the next rising edge,
    // and the model advances with exactly what the DUT sampled.
    task automatic cyc(input bit e, input bit d);
        logic [W-1:0] w;
        ena = e;
        din = d;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (e) begin
            partial.push_back(d);
            if (partial.size() == W) begin
                w = '0;
                foreach (partial[i]) w = {w[W-2:0], partial[i]};
                exp_words.push_back(w);
                last_word = w;
                partial.delete();
            end
        end else if (partial.size() > 0) begin
`ifdef RX_SERIAL_ERR_EN
            partial.delete();
            exp_errs++;
`endif
        end
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] v, input int n);
        logic [W-1:0] t;
        t = v;
        for (int i = 0; i < n; i++) cyc(1'b1, t[W-1-i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic reset_pulse(input int n);
        rst = 1'b1;
        model_clear();
        for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rst = 1'b0;
    endtask

    // Monitor: every cycle, compare DUT outputs against the scoreboard.
    initial begin
        logic [W-1:0] w;
        forever begin
            @(negedge clk);
            check("valid_o", {31'd0, valid_o}, {31'd0, exp_words.size() > 0});
            if (valid_o && exp_words.size() > 0) begin
                w = exp_words.pop_front();
                check("word", {24'd0, data_o}, {24'd0, w});
            end
            check("data_o_hold", {24'd0, data_o}, {24'd0, last_word});
            check("busy_o", {31'd0, busy_o}, {31'd0, partial.size() > 0});
            check("err_o", {31'd0, err_o}, {31'd0, exp_errs > 0});
            if (exp_errs > 0) exp_errs--;
        end
    end

    initial begin
        rst = 1'b0;
        ena = 1'b0;
        din = 1'b0;
        model_clear();
        #1;
        // reset with random inputs, then quiet release
        reset_pulse(3);
        idle(5);

        // single word A5
        send_bits(8'hA5, W);
        idle(3);

        // back-to-back A5, 3C
        send_bits(8'hA5, W);
        send_bits(8'h3C, W);
        idle(3);

        // gap inside a word
`ifdef RX_SERIAL_ERR_EN
        send_bits(8'hFF, 3);
        idle(1);
        send_bits(8'h81, W);
`else
        send_bits(8'hC0, 3);
        idle(4);
        send_bits(8'h68, 5);
`endif
        idle(3);

        // reset mid-word, then a clean word
        send_bits(8'hFF, 5);
        reset_pulse(1);
        send_bits(8'h5A, W);
        idle(3);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse(1);
            else cyc($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
